// File: rtl/vx_reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package vx_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } seq_state_e;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_reset_seq_arb.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer;
// the pointer advances past the winner only when en is high.
module vx_reset_seq_arb
    import vx_reset_seq_pkg::*;
#(
    parameter int NUM_REQS = 2,
    parameter int IDX_W    = idx_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                en,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int off = 0; off < NUM_REQS; off++) begin
            cand = IDX_W'((int'(ptr_q) + off) % NUM_REQS);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vx_reset_sequencer.sv
// Reset sequencer: holds masked groups in reset, then releases them in ascending order.
// Define VX_RESET_SEQ_PERF_EN to add the perf_seq_count completed-sequence counter.
module vx_reset_sequencer
    import vx_reset_seq_pkg::*;
#(
    parameter int N           = 4,
    parameter int NUM_REQS    = 2,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGGER     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQS-1:0]   req_valid,
    input  logic [NUM_REQS*N-1:0] req_mask,
    output logic [NUM_REQS-1:0]   req_ready,
    output logic [N-1:0]          reset_o,
    output logic                  busy,
    output logic                  done
`ifdef VX_RESET_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_seq_count
`endif
);

    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int STAG_W = cnt_w(STAGGER);
    localparam int IDX_W  = idx_w(NUM_REQS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);

    seq_state_e          state_q, state_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [N-1:0]        rst_q, rst_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STAG_W-1:0]   stag_q, stag_d;
    logic                done_d;

    logic [NUM_REQS-1:0] grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                arb_open;
    logic                handshake;
    logic [N-1:0]        sel_mask;
    logic [N-1:0]        remaining;
    logic [N-1:0]        lowest;
    logic                last_one;

    vx_reset_seq_arb #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .en        (handshake),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign arb_open  = (state_q == ST_IDLE) && !reset;
    assign req_ready = arb_open ? grant : '0;
    assign handshake = |req_ready;

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) sel_mask = sel_mask | req_mask[i*N +: N];
        end
    end

    // Masked groups still held; releases go lowest-first so the next victim is the lowest set bit.
    assign remaining = mask_q & rst_q;
    assign lowest    = remaining & (~remaining + N'(1));
    assign last_one  = (remaining & (remaining - N'(1))) == '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        rst_d   = rst_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    mask_d = sel_mask;
                    hold_d = '0;
                    stag_d = '0;
                    if (sel_mask == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        rst_d   = rst_q | sel_mask;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    rst_d   = rst_q & ~lowest;
                    stag_d  = '0;
                    done_d  = last_one;
                    state_d = ST_RELEASE;
                end else if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (remaining == '0) begin
                    state_d = ST_DONE;
                end else if (stag_q >= STAG_LAST) begin
                    rst_d  = rst_q & ~lowest;
                    stag_d = '0;
                    done_d = last_one;
                end else begin
                    stag_d = stag_q + STAG_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset restarts a full all-groups sequence from the top of HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
            mask_q  <= '1;
            rst_q   <= '1;
            hold_q  <= '0;
            stag_q  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            rst_q   <= rst_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            done    <= done_d;
        end
    end

    assign reset_o = rst_q;
    assign busy    = (state_q != ST_IDLE);

`ifdef VX_RESET_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) perf_seq_count <= '0;
        else if (done) perf_seq_count <= perf_seq_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_vx_reset_sequencer.sv
// Bench for vx_reset_sequencer: directed scenarios then random requests and aborts,
// checked every cycle against a release-timetable model.
module tb_vx_reset_sequencer;

    localparam int N    = 4;
    localparam int NR   = 2;
    localparam int HOLD = 8;
    localparam int STAG = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*N-1:0] req_mask;
    logic [NR-1:0]   req_ready;
    logic [N-1:0]    reset_o;
    logic            busy;
    logic            done;
`ifdef VX_RESET_SEQ_PERF_EN
    logic [31:0]     perf_seq_count;
`endif

    always #5 clk = ~clk;

    vx_reset_sequencer #(
        .N           (N),
        .NUM_REQS    (NR),
        .HOLD_CYCLES (HOLD),
        .STAGGER     (STAG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_mask       (req_mask),
        .req_ready      (req_ready),
        .reset_o        (reset_o),
        .busy           (busy),
        .done           (done)
`ifdef VX_RESET_SEQ_PERF_EN
        ,
        .perf_seq_count (perf_seq_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    int now   = 0;

    // Model: expected reset vector plus a timetable of when each group drops.
    logic [N-1:0] m_rst;
    logic [N-1:0] a_mask;
    int           a_at, done_at, idle_at, ptr, seqs, hs_at;
    int           rel_at [N];
    bit           pend   [NR];
    logic [N-1:0] pmask  [NR];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0h want %0h", tag, now, act, exp);
        end
    endtask

    // Masked groups drop HOLD cycles after h, ascending, STAG apart; done with the last.
    function automatic void sched(input int h, input logic [N-1:0] m);
        int j;
        j = 0;
        for (int g = 0; g < N; g++) begin
            rel_at[g] = -1;
            if (m[g]) begin
                rel_at[g] = h + HOLD + j * STAG;
                done_at   = rel_at[g];
                j++;
            end
        end
        idle_at = done_at + 2;
    endfunction

    function automatic void power_on(input int h);
        m_rst = '1;
        a_at  = -1;
        ptr   = 0;
        sched(h, '1);
    endfunction

    task automatic cycle(input bit rst_in);
        logic [NR-1:0] g;
        int            idx;
        reset = rst_in;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]         = pend[i];
            req_mask[i*N +: N]   = pmask[i];
        end
        #1;
        if (now == a_at) m_rst = m_rst | a_mask;
        for (int k = 0; k < N; k++) if (rel_at[k] == now) m_rst[k] = 1'b0;
        g = '0;
        if (!rst_in && now >= idle_at) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr + k) % NR;
                if (g == '0 && pend[idx]) g[idx] = 1'b1;
            end
        end
        chk("reset_o",   32'(reset_o),   32'(m_rst));
        chk("done",      32'(done),      32'(now == done_at));
        chk("busy",      32'(busy),      32'(now < idle_at));
        chk("req_ready", 32'(req_ready), 32'(g));
        if (rst_in) begin
            seqs = 0;
            power_on(now + 1);
        end else begin
            if (now == done_at) seqs++;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    ptr     = (i + 1) % NR;
                    pend[i] = 1'b0;
                    hs_at   = now;
                    if (pmask[i] == '0) begin
                        for (int k = 0; k < N; k++) rel_at[k] = -1;
                        done_at = now + 1;
                        idle_at = now + 2;
                    end else begin
                        a_at   = now + 1;
                        a_mask = pmask[i];
                        sched(now + 1, pmask[i]);
                    end
                end
            end
        end
        @(negedge clk);
        now++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0);
    endtask

    task automatic run_rand(input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1'b1;
                    pmask[i] = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
                end
            end
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            pend[i]  = 1'b0;
            pmask[i] = '0;
        end
        // Requester 0 waits through power-on with 0101: the single-request case.
        pend[0]   = 1'b1;
        pmask[0]  = 4'b0101;
        reset     = 1'b1;
        req_valid = 2'b01;
        req_mask  = {4'b0000, 4'b0101};
        seqs      = 0;
        hs_at     = -1;

        @(posedge clk);
        @(negedge clk);
        chk("rst_reset_o",   32'(reset_o),   32'hF);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy",      32'(busy),      32'h1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        now = 0;
        power_on(0);
        run(30);                         // power-on timeline, then req0 0101 at cycle 16

        pend[1] = 1'b1; pmask[1] = 4'b0000;
        run(6);                          // zero mask on req1, pointer back to 0

        pend[0] = 1'b1; pmask[0] = 4'b0011;
        pend[1] = 1'b1; pmask[1] = 4'b1000;
        run(30);                         // contention: req0 first, then req1

        pend[0] = 1'b1; pmask[0] = 4'b1111;
        hs_at = -1;
        for (int k = 0; k < 50 && hs_at < 0; k++) cycle(1'b0);
        chk("abort_grant_seen", 32'(hs_at >= 0), 32'h1);
        while (now < hs_at + 10) cycle(1'b0);
        cycle(1'b1);                     // abort after group 0 has dropped
        run(20);

        run_rand(700);
        run(80);                         // drain whatever is still pending

`ifdef VX_RESET_SEQ_PERF_EN
        chk("perf_seq_count", perf_seq_count, 32'(seqs));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
